// File: rtl/calc_alu_pkg.sv
// Shared command encodings and widths for the calculator ALU.
// The optional divider is enabled by defining CALC_ALU_DIV_EN.
package calc_alu_pkg;

   localparam int OPW  = 4;
   localparam int RESW = 8;

   localparam logic [2:0] OP_NOOP     = 3'b000;
   localparam logic [2:0] OP_DISP_A   = 3'b010;
   localparam logic [2:0] OP_DISP_B   = 3'b100;
   localparam logic [2:0] OP_COMPUTE  = 3'b101;
   localparam logic [2:0] OP_DISP_RES = 3'b110;

   localparam logic [1:0] CMP_ADD = 2'b00;
   localparam logic [1:0] CMP_SUB = 2'b01;
   localparam logic [1:0] CMP_MUL = 2'b10;
   localparam logic [1:0] CMP_DIV = 2'b11;

   // Zero-extends an operand to the result width.
   function automatic logic [RESW-1:0] widen(input logic [OPW-1:0] v);
      return {{(RESW-OPW){1'b0}}, v};
   endfunction

endpackage

// File: rtl/calc_alu_div.sv
// Combinational 4-bit restoring divider; divisor 0 yields zero outputs and dz=1.
module calc_alu_div
   import calc_alu_pkg::*;
(
   input  logic [OPW-1:0] dividend,
   input  logic [OPW-1:0] divisor,
   output logic [OPW-1:0] quotient,
   output logic [OPW-1:0] remainder,
   output logic           dz
);

   // rem_stage[gi] is the partial remainder entering stage gi (MSB first).
   logic [OPW-1:0] rem_stage [OPW+1];
   logic [OPW-1:0] quot_bits;

   assign rem_stage[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < OPW; gi++) begin : g_stage
         logic [OPW:0]   shifted;
         logic [OPW+1:0] diff;
         assign shifted = {rem_stage[gi], dividend[OPW-1-gi]};
         assign diff    = {1'b0, shifted} - {2'b00, divisor};
         // No borrow means the divisor fits: keep the difference, quotient bit 1.
         assign quot_bits[OPW-1-gi] = ~diff[OPW+1];
         assign rem_stage[gi+1]     = diff[OPW+1] ? shifted[OPW-1:0] : diff[OPW-1:0];
      end
   endgenerate

   always_comb begin
      dz        = (divisor == '0);
      quotient  = dz ? '0 : quot_bits;
      remainder = dz ? '0 : rem_stage[OPW];
   end

endmodule

// File: rtl/calc_alu.sv
// Registered 4-bit add/sub/mul/div and display-routing unit for the calculator.
// Define CALC_ALU_DIV_EN to build the divider; otherwise DIV returns 0.
module calc_alu
   import calc_alu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  A,
   input  logic [OPW-1:0]  B,
   input  logic [2:0]      op_code,
   input  logic [1:0]      compute_op,
   output logic [RESW-1:0] result,
   output logic            done,
   output logic            negative,
   output logic            div_by_zero
);

   logic [RESW-1:0] result_reg, result_next;
   logic            done_reg, done_next;
   logic            neg_reg, neg_next;
   logic            dz_reg, dz_next;
   logic [RESW-1:0] last_result_reg, last_result_next;
   logic            last_neg_reg, last_neg_next;
   logic            last_dz_reg, last_dz_next;

`ifdef CALC_ALU_DIV_EN
   logic [OPW-1:0] div_quot;
   logic [OPW-1:0] div_rem;
   logic           div_dz;

   calc_alu_div u_div (
      .dividend  (A),
      .divisor   (B),
      .quotient  (div_quot),
      .remainder (div_rem),
      .dz        (div_dz)
   );
`endif

   // Value and flags a COMPUTE would produce this cycle.
   logic [RESW-1:0] cmp_res;
   logic            cmp_neg;
   logic            cmp_dz;

   always_comb begin
      cmp_res = '0;
      cmp_neg = 1'b0;
      cmp_dz  = 1'b0;
      case (compute_op)
         CMP_ADD: cmp_res = widen(A) + widen(B);
         CMP_SUB: begin
            cmp_neg = (A < B);
            cmp_res = cmp_neg ? widen(B - A) : widen(A - B);
         end
         CMP_MUL: cmp_res = widen(A) * widen(B);
         default: begin
`ifdef CALC_ALU_DIV_EN
            cmp_res = {div_rem, div_quot};
            cmp_dz  = div_dz;
`else
            cmp_res = '0;
`endif
         end
      endcase
   end

   always_comb begin
      result_next      = result_reg;
      done_next        = 1'b0;
      neg_next         = 1'b0;
      dz_next          = 1'b0;
      last_result_next = last_result_reg;
      last_neg_next    = last_neg_reg;
      last_dz_next     = last_dz_reg;
      case (op_code)
         OP_COMPUTE: begin
            result_next      = cmp_res;
            done_next        = 1'b1;
            neg_next         = cmp_neg;
            dz_next          = cmp_dz;
            last_result_next = cmp_res;
            last_neg_next    = cmp_neg;
            last_dz_next     = cmp_dz;
         end
         OP_DISP_A:   result_next = widen(A);
         OP_DISP_B:   result_next = widen(B);
         OP_DISP_RES: begin
            result_next = last_result_reg;
            neg_next    = last_neg_reg;
            dz_next     = last_dz_reg;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_reg      <= '0;
         done_reg        <= 1'b0;
         neg_reg         <= 1'b0;
         dz_reg          <= 1'b0;
         last_result_reg <= '0;
         last_neg_reg    <= 1'b0;
         last_dz_reg     <= 1'b0;
      end else begin
         result_reg      <= result_next;
         done_reg        <= done_next;
         neg_reg         <= neg_next;
         dz_reg          <= dz_next;
         last_result_reg <= last_result_next;
         last_neg_reg    <= last_neg_next;
         last_dz_reg     <= last_dz_next;
      end
   end

   assign result      = result_reg;
   assign done        = done_reg;
   assign negative    = neg_reg;
   assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_calc_alu.sv
// Scoreboard bench for calc_alu: directed walk plus random commands vs a reference model.
module tb_calc_alu;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] A = '0;
   logic [3:0] B = '0;
   logic [2:0] op_code = '0;
   logic [1:0] compute_op = '0;
   logic [7:0] result;
   logic       done, negative, div_by_zero;

   calc_alu dut (
      .clk         (clk),
      .reset       (reset),
      .A           (A),
      .B           (B),
      .op_code     (op_code),
      .compute_op  (compute_op),
      .result      (result),
      .done        (done),
      .negative    (negative),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] res;
      logic       done;
      logic       neg;
      logic       dz;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   txn    = 0;

   // Reference state: what the display shows and the remembered computation.
   int m_shown = 0;
   int m_last_val = 0;
   bit m_last_neg = 0;
   bit m_last_dz = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (txn %0d)", name, got, want, txn);
      end
   endtask

   function automatic exp_t model(input int a, input int b, input int op, input int cop);
      exp_t e;
      int   v;
      bit   n, z;
      e = '0;
      if (op == 5) begin
         v = 0; n = 0; z = 0;
         if (cop == 0) v = a + b;
         else if (cop == 1) begin
            n = (a < b);
            v = n ? b - a : a - b;
         end else if (cop == 2) v = a * b;
         else begin
`ifdef CALC_ALU_DIV_EN
            if (b == 0) z = 1;
            else v = (a % b) * 16 + (a / b);
`endif
         end
         m_shown = v; m_last_val = v; m_last_neg = n; m_last_dz = z;
         e.done = 1; e.neg = n; e.dz = z;
      end else if (op == 2) m_shown = a;
      else if (op == 4) m_shown = b;
      else if (op == 6) begin
         m_shown = m_last_val;
         e.neg = m_last_neg;
         e.dz = m_last_dz;
      end
      e.res = m_shown[7:0];
      return e;
   endfunction

   task automatic issue(input int a, input int b, input int op, input int cop);
      @(negedge clk);
      A = a[3:0]; B = b[3:0]; op_code = op[2:0]; compute_op = cop[1:0];
      exp_q.push_back(model(a, b, op, cop));
   endtask

   // Monitor: every sampled edge presents one response.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            chk("result", result, e.res);
            chk("done", done, e.done);
            chk("negative", negative, e.neg);
            chk("div_by_zero", div_by_zero, e.dz);
            $display("txn %0d A=%0d B=%0d op=%0d cop=%0d -> result=%0d done=%0b neg=%0b dz=%0b",
                     txn, A, B, op_code, compute_op, result, done, negative, div_by_zero);
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #1;
      chk("reset_result", result, 0);
      chk("reset_done", done, 0);
      chk("reset_flags", {negative, div_by_zero}, 0);
      @(negedge clk);
      reset = 1'b1;

      // Directed walk from the test plan.
      issue(5, 3, 5, 0);
      issue(3, 5, 5, 1);
      issue(9, 9, 5, 1);
      issue(4, 2, 5, 2);
      issue(15, 15, 5, 2);
      issue(7, 3, 5, 3);
      issue(7, 0, 5, 3);
      issue(9, 6, 2, 0);
      issue(9, 6, 4, 0);
      issue(9, 6, 6, 0);
      issue(9, 6, 0, 0);
      issue(15, 14, 5, 2);
      drain();

      // Asynchronous reset between edges must clear outputs before the next edge.
      @(negedge clk);
      op_code = 3'b000;
      reset = 1'b0;
      #1;
      chk("async_rst_result", result, 0);
      chk("async_rst_flags", {done, negative, div_by_zero}, 0);
      m_shown = 0; m_last_val = 0; m_last_neg = 0; m_last_dz = 0;
      #1 reset = 1'b1;
      issue(3, 4, 6, 0);
      issue(0, 15, 5, 1);
      issue(0, 0, 5, 3);
      issue(15, 1, 5, 3);

      // Random commands, biased toward COMPUTE.
      for (int i = 0; i < 400; i++) begin
         int op;
         op = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : 5;
         issue($urandom_range(0, 15), $urandom_range(0, 15), op, $urandom_range(0, 3));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
